// File: rtl/exec_unit.sv
// Execute stage: 64-entry register file, single-cycle ALU and an optional
// shift-add multiplier enabled with the EXEC_MUL_EN macro.
module exec_unit #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  logic [3:0]        opcode_i,
    input  logic [5:0]        rm_i,
    input  logic [5:0]        rn_i,
    output logic [DATA_W-1:0] result_o,
    output logic              result_valid_o,
    output logic              zero_flag_o,
    output logic              busy_o,
    input  logic [5:0]        dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    localparam logic [3:0] OP_INC = 4'h1;
    localparam logic [3:0] OP_DEC = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_MOV = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_MUL = 4'h7;
    localparam logic [3:0] OP_AND = 4'h8;
    localparam logic [3:0] OP_OR  = 4'h9;
    localparam logic [3:0] OP_XOR = 4'hA;
    localparam logic [3:0] OP_NOT = 4'hB;

    logic [DATA_W-1:0] regs_q [64];
    logic [DATA_W-1:0] result_q;
    logic              result_valid_q;
    logic              zero_q;

    logic [DATA_W-1:0] op_a, op_b, imm, alu_y;
    logic              alu_wr;
    logic              accept;
    logic              wr_en;
    logic [5:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;

    assign accept     = issue_valid_i && issue_ready_o;
    assign op_a       = regs_q[rm_i];
    assign op_b       = regs_q[rn_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

    // LDI immediate: zero-extend rn, truncating when DATA_W is narrower than 6
    always_comb begin
        imm = '0;
        for (int i = 0; i < DATA_W && i < 6; i++) imm[i] = rn_i[i];
    end

    always_comb begin
        alu_y  = '0;
        alu_wr = 1'b1;
        case (opcode_i)
            OP_INC:  alu_y = op_a + 1'b1;
            OP_DEC:  alu_y = op_a - 1'b1;
            OP_ADD:  alu_y = op_a + op_b;
            OP_SUB:  alu_y = op_a - op_b;
            OP_MOV:  alu_y = op_b;
            OP_LDI:  alu_y = imm;
            OP_MUL:  alu_wr = 1'b0;
            OP_AND:  alu_y = op_a & op_b;
            OP_OR:   alu_y = op_a | op_b;
            OP_XOR:  alu_y = op_a ^ op_b;
            OP_NOT:  alu_y = ~op_a;
            default: alu_wr = 1'b0;
        endcase
    end

`ifdef EXEC_MUL_EN
    // state  | meaning
    // S_IDLE | ready; single-cycle ops retire here, MUL captures operands
    // S_MUL  | shift-add iteration, write on cnt==0
    localparam int CNT_W = ($clog2(DATA_W) < 4) ? 4 : $clog2(DATA_W);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_next;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [5:0]        dst_q, dst_d;
    logic              mul_wr;

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        dst_d    = dst_q;
        mul_wr   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && opcode_i == OP_MUL) begin
                    state_d  = S_MUL;
                    acc_d    = '0;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    cnt_d    = CNT_W'(DATA_W - 1);
                    dst_d    = rm_i;
                end
            end
            S_MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == '0) begin
                    mul_wr  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            dst_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            dst_q    <= dst_d;
        end
    end

    // No accept can happen in S_MUL, so the two write sources never collide
    assign issue_ready_o = (state_q == S_IDLE);
    assign wr_en         = (accept && alu_wr) || mul_wr;
    assign wr_addr       = mul_wr ? dst_q : rm_i;
    assign wr_data       = mul_wr ? acc_next : alu_y;
`else
    assign issue_ready_o = 1'b1;
    assign wr_en         = accept && alu_wr;
    assign wr_addr       = rm_i;
    assign wr_data       = alu_y;
`endif

    assign busy_o = ~issue_ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) regs_q[i] <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            zero_q         <= 1'b0;
        end else begin
            result_valid_q <= wr_en;
            if (wr_en) begin
                regs_q[wr_addr] <= wr_data;
                result_q        <= wr_data;
                zero_q          <= (wr_data == '0);
            end
        end
    end

    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign zero_flag_o    = zero_q;

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: directed scenarios plus random traffic against an
// arithmetic register-file model; MUL scenarios only when EXEC_MUL_EN is set.
module tb_exec_unit;

    localparam int W = 8;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         issue_valid_i;
    logic         issue_ready_o;
    logic [3:0]   opcode_i;
    logic [5:0]   rm_i, rn_i, dbg_addr_i;
    logic [W-1:0] result_o, dbg_data_o;
    logic         result_valid_o, zero_flag_o, busy_o;

    always #5 clk = ~clk;

    exec_unit #(.DATA_W(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid_i  (issue_valid_i),
        .issue_ready_o  (issue_ready_o),
        .opcode_i       (opcode_i),
        .rm_i           (rm_i),
        .rn_i           (rn_i),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .zero_flag_o    (zero_flag_o),
        .busy_o         (busy_o),
        .dbg_addr_i     (dbg_addr_i),
        .dbg_data_o     (dbg_data_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference state
    int mreg [64];
    int m_res, m_zero, m_rv;
    bit m_pend, m_acc;
    int m_left, m_dst, m_prod;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) mreg[i] = 0;
        m_res = 0; m_zero = 0; m_rv = 0;
        m_pend = 0; m_acc = 0; m_left = 0; m_dst = 0; m_prod = 0;
    endfunction

    function automatic void model_write(input int d, input int v);
        mreg[d] = v % M;
        m_res   = v % M;
        m_zero  = (v % M == 0);
        m_rv    = 1;
    endfunction

    // one rising edge of behaviour, applied with the inputs currently driven
    function automatic void model_step();
        int a, b, y;
        bit wr;
        m_rv  = 0;
        m_acc = 0;
        if (m_pend) begin
            if (m_left == 1) begin
                model_write(m_dst, m_prod);
                m_pend = 0;
            end else begin
                m_left--;
            end
        end else if (issue_valid_i) begin
            m_acc = 1;
            a  = mreg[rm_i];
            b  = mreg[rn_i];
            wr = 1;
            y  = 0;
            case (int'(opcode_i))
                1:  y = a + 1;
                2:  y = a + M - 1;
                3:  y = a + b;
                4:  y = a + M - b;
                5:  y = b;
                6:  y = int'(rn_i);
                7: begin
                    wr = 0;
`ifdef EXEC_MUL_EN
                    m_pend = 1;
                    m_left = W;
                    m_dst  = int'(rm_i);
                    m_prod = (a * b) % M;
`endif
                end
                8:  y = a & b;
                9:  y = a | b;
                10: y = a ^ b;
                11: y = (M - 1) - a;
                default: wr = 0;
            endcase
            if (wr) model_write(int'(rm_i), y);
        end
    endfunction

    task automatic check_all();
        int da;
        chk("result", 32'(result_o), 32'(m_res));
        chk("result_valid", 32'(result_valid_o), 32'(m_rv));
        chk("zero_flag", 32'(zero_flag_o), 32'(m_zero));
        chk("issue_ready", 32'(issue_ready_o), 32'(!m_pend));
        chk("busy", 32'(busy_o), 32'(m_pend));
        da = $urandom_range(63);
        dbg_addr_i = 6'(da);
        #1;
        chk("dbg_data", 32'(dbg_data_o), 32'(mreg[da]));
    endtask

    task automatic cyc(input bit v, input int op, input int rm, input int rn);
        issue_valid_i = v;
        opcode_i      = 4'(op);
        rm_i          = 6'(rm);
        rn_i          = 6'(rn);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic dbg_chk(input string tag, input int addr, input int exp);
        dbg_addr_i = 6'(addr);
        #1;
        chk(tag, 32'(dbg_data_o), 32'(exp));
    endtask

    task automatic all_zero_chk();
        for (int i = 0; i < 64; i++) dbg_chk("reg_zero", i, 0);
    endtask

    initial begin
        int low_cnt;
        rst_n = 1'b0;
        issue_valid_i = 1'b0;
        opcode_i = '0; rm_i = '0; rn_i = '0; dbg_addr_i = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        all_zero_chk();
        rst_n = 1'b1;

        // LDI/INC then doubling via MOV+ADD
        cyc(1, 6, 3, 5);
        cyc(1, 1, 3, 0);
        chk("inc_rv", 32'(result_valid_o), 1);
        cyc(1, 5, 4, 3);
        cyc(1, 3, 4, 3);
        chk("add_result", 32'(result_o), 12);
        cyc(0, 0, 0, 0);
        dbg_chk("r3", 3, 6);
        dbg_chk("r4", 4, 12);

        // zero flag and wraparound
        cyc(1, 6, 1, 1);
        cyc(1, 4, 1, 1);
        chk("sub_self_res", 32'(result_o), 0);
        chk("sub_self_zero", 32'(zero_flag_o), 1);
        cyc(1, 2, 1, 0);
        chk("dec_wrap_res", 32'(result_o), 32'hFF);
        chk("dec_wrap_zero", 32'(zero_flag_o), 0);
        cyc(0, 0, 0, 0);
        chk("rv_drop", 32'(result_valid_o), 0);

        // opcode 7: iterative MUL or single-cycle no-op depending on build
        cyc(1, 6, 2, 13);
        cyc(1, 6, 5, 11);
        cyc(1, 7, 2, 5);
        low_cnt = 0;
        for (int i = 0; i < 20 && m_pend; i++) begin
            if (!issue_ready_o) low_cnt++;
            cyc(1, 7, 2, 5);
        end
        cyc(0, 0, 0, 0);
`ifdef EXEC_MUL_EN
        chk("mul_ready_low", 32'(low_cnt), W);
        dbg_chk("mul_13x11", 2, 143);
        cyc(1, 7, 2, 2);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 7, 0);
            if (m_acc) break;
        end
        chk("inc_after_mul", 32'(m_acc), 1);
        cyc(0, 0, 0, 0);
        dbg_chk("mul_square", 2, 32'hE1);
        dbg_chk("r7_once", 7, 1);
`else
        chk("op7_no_stall", 32'(low_cnt), 0);
        dbg_chk("op7_no_write", 2, 13);
`endif

        // reset during a MUL (or plain traffic) aborts without writing
        cyc(1, 6, 9, 7);
        cyc(1, 7, 9, 9);
        repeat (3) cyc(0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("rst_ready", 32'(issue_ready_o), 1);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_rv", 32'(result_valid_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) cyc(0, 0, 0, 0);
        all_zero_chk();

        // decoder-owned and NOP opcodes never write
        cyc(1, 6, 10, 42);
        for (int i = 0; i < 24; i++) begin
            int op;
            op = (i % 5 == 0) ? 0 : 12 + $urandom_range(3);
            cyc(1, op, $urandom_range(63), $urandom_range(63));
        end
        dbg_chk("r10_kept", 10, 42);

        // random traffic; hold a held instruction while busy like fetch does
        begin
            bit v;
            int op, rm, rn;
            v = 0; op = 0; rm = 0; rn = 0;
            for (int i = 0; i < 600; i++) begin
                if (!m_pend) begin
                    v  = ($urandom_range(3) != 0);
                    op = $urandom_range(15);
                    rm = $urandom_range(7);
                    rn = (op == 6) ? $urandom_range(63) : $urandom_range(7);
                end
                cyc(v, op, rm, rn);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
